// File: rtl/complex_div.sv
// complex_div: iterative saturating complex divider q = a / b, signed Q1.(W-1) in and out.
// Define COMPLEX_DIV_ROUND_EN to add a guard bit and round half away from zero.
module complex_div #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a_r,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_r,
   input  logic [W-1:0] b_i,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] q_r,
   output logic [W-1:0] q_i,
   output logic         ovf,
   output logic         div0
);

`ifdef COMPLEX_DIV_ROUND_EN
   localparam int ITER = W;
`else
   localparam int ITER = W - 1;
`endif
   localparam int PW = 2 * W;
   localparam int NW = 2 * W + 1;
   localparam int CW = $clog2(ITER + 1);

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      PREP,
      DIV,
      FIN
   } state_t;

   state_t state;

   logic signed [W-1:0]  op_ar, op_ai, op_br, op_bi;
   logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri, sq_r, sq_i;
   logic [PW-1:0]        den;
   logic [NW-1:0]        rem_r, rem_i;
   logic [ITER-1:0]      quo_r, quo_i;
   logic                 sign_r, sign_i, sat_r, sat_i;
   logic [CW-1:0]        iter_cnt;

   logic signed [NW-1:0] num_r, num_i;
   logic [NW-1:0]        abs_r, abs_i;
   logic [PW-1:0]        den_c;
   logic [NW-1:0]        den_x, trial_r, trial_i, next_r, next_i;
   logic                 bit_r, bit_i;
   logic [W-1:0]         mag_r, mag_i;
   logic                 clip_r, clip_i;

   function automatic logic signed [PW-1:0] sx(input logic signed [W-1:0] v);
      return {{W{v[W-1]}}, v};
   endfunction

   // Saturate to the format limits on clip, otherwise apply the sign to the magnitude.
   function automatic logic [W-1:0] shape(input logic neg, input logic clip,
                                          input logic [W-1:0] mag);
      logic [W-1:0] res;
      if (clip)
         res = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         res = neg ? -mag : mag;
      return res;
   endfunction

   // Numerators of a*conj(b), their magnitudes, and |b|^2 from the registered products.
   always_comb begin
      num_r = {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
      num_i = {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
      abs_r = num_r[NW-1] ? -num_r : num_r;
      abs_i = num_i[NW-1] ? -num_i : num_i;
      den_c = sq_r + sq_i;
   end

   // One restoring step per component against the shared denominator.
   always_comb begin
      den_x   = {1'b0, den};
      trial_r = rem_r << 1;
      trial_i = rem_i << 1;
      bit_r   = (trial_r >= den_x);
      bit_i   = (trial_i >= den_x);
      next_r  = bit_r ? trial_r - den_x : trial_r;
      next_i  = bit_i ? trial_i - den_x : trial_i;
   end

   // The guard bit drives rounding; a rounded magnitude of 1.0 has to saturate too.
   always_comb begin
`ifdef COMPLEX_DIV_ROUND_EN
      mag_r  = (quo_r >> 1) + {{(W-1){1'b0}}, quo_r[0]};
      mag_i  = (quo_i >> 1) + {{(W-1){1'b0}}, quo_i[0]};
      clip_r = sat_r | mag_r[W-1];
      clip_i = sat_i | mag_i[W-1];
`else
      mag_r  = {1'b0, quo_r};
      mag_i  = {1'b0, quo_i};
      clip_r = sat_r;
      clip_i = sat_i;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         q_r      <= '0;
         q_i      <= '0;
         ovf      <= 1'b0;
         div0     <= 1'b0;
         op_ar    <= '0;
         op_ai    <= '0;
         op_br    <= '0;
         op_bi    <= '0;
         p_rr     <= '0;
         p_ii     <= '0;
         p_ir     <= '0;
         p_ri     <= '0;
         sq_r     <= '0;
         sq_i     <= '0;
         den      <= '0;
         rem_r    <= '0;
         rem_i    <= '0;
         quo_r    <= '0;
         quo_i    <= '0;
         sign_r   <= 1'b0;
         sign_i   <= 1'b0;
         sat_r    <= 1'b0;
         sat_i    <= 1'b0;
         iter_cnt <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_ar <= a_r;
                  op_ai <= a_i;
                  op_br <= b_r;
                  op_bi <= b_i;
                  busy  <= 1'b1;
                  state <= MUL;
               end
            end
            MUL: begin
               p_rr  <= sx(op_ar) * sx(op_br);
               p_ii  <= sx(op_ai) * sx(op_bi);
               p_ir  <= sx(op_ai) * sx(op_br);
               p_ri  <= sx(op_ar) * sx(op_bi);
               sq_r  <= sx(op_br) * sx(op_br);
               sq_i  <= sx(op_bi) * sx(op_bi);
               state <= PREP;
            end
            PREP: begin
               sign_r   <= num_r[NW-1];
               sign_i   <= num_i[NW-1];
               rem_r    <= abs_r;
               rem_i    <= abs_i;
               sat_r    <= (abs_r >= {1'b0, den_c});
               sat_i    <= (abs_i >= {1'b0, den_c});
               den      <= den_c;
               quo_r    <= '0;
               quo_i    <= '0;
               iter_cnt <= '0;
               state    <= DIV;
            end
            DIV: begin
               rem_r    <= next_r;
               rem_i    <= next_i;
               quo_r    <= {quo_r[ITER-2:0], bit_r};
               quo_i    <= {quo_i[ITER-2:0], bit_i};
               iter_cnt <= iter_cnt + CW'(1);
               if (iter_cnt == CW'(ITER - 1))
                  state <= FIN;
            end
            FIN: begin
               if (den == '0) begin
                  q_r  <= '0;
                  q_i  <= '0;
                  ovf  <= 1'b0;
                  div0 <= 1'b1;
               end else begin
                  q_r  <= shape(sign_r, clip_r, mag_r);
                  q_i  <= shape(sign_i, clip_i, mag_i);
                  ovf  <= clip_r | clip_i;
                  div0 <= 1'b0;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_complex_div.sv
// tb_complex_div: randomized self-checking bench for complex_div against an exact rational model.
// Honours COMPLEX_DIV_ROUND_EN in the same way as the design.
module tb_complex_div;

   localparam int W = 24;
`ifdef COMPLEX_DIV_ROUND_EN
   localparam int ITER = W;
`else
   localparam int ITER = W - 1;
`endif
   localparam int LAT = ITER + 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0;
   logic         busy, done, ovf, div0;
   logic [W-1:0] q_r, q_i;

   typedef struct {
      int           due;
      logic [W-1:0] qr;
      logic [W-1:0] qi;
      logic         ov;
      logic         d0;
   } exp_t;

   exp_t         pending[$];
   logic [W-1:0] last_qr = '0, last_qi = '0;
   logic         last_ov = 1'b0, last_d0 = 1'b0;
   int           cyc = 0;
   int           checks = 0;
   int           failures = 0;

   complex_div #(.W(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .a_r  (a_r),
      .a_i  (a_i),
      .b_r  (b_r),
      .b_i  (b_i),
      .busy (busy),
      .done (done),
      .q_r  (q_r),
      .q_i  (q_i),
      .ovf  (ovf),
      .div0 (div0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // One component: exact |num|/den scaled to the output format, then truncate or round.
   function automatic void modelComponent(input longint num, input longint den,
                                          output logic [W-1:0] q, output logic sat);
      logic [127:0] absn, raw, mag, limit;
      logic         neg;
      neg   = (num < 0);
      absn  = neg ? 128'(-num) : 128'(num);
      limit = 128'(1) << (W - 1);
      sat   = 1'b0;
      mag   = '0;
      if (absn >= 128'(den)) begin
         sat = 1'b1;
      end else begin
         raw = (absn << ITER) / 128'(den);
`ifdef COMPLEX_DIV_ROUND_EN
         mag = (raw + 128'(1)) >> 1;
`else
         mag = raw;
`endif
         if (mag >= limit) sat = 1'b1;
      end
      if (sat)
         q = neg ? W'(limit) : W'(limit - 128'(1));
      else
         q = neg ? W'(128'(0) - mag) : W'(mag);
   endfunction

   function automatic exp_t modelDivide(input logic [W-1:0] ar, input logic [W-1:0] ai,
                                        input logic [W-1:0] br, input logic [W-1:0] bi);
      exp_t   e;
      longint sar, sai, sbr, sbi, nr, ni, den;
      logic   sr, si;
      sar = longint'($signed(ar));
      sai = longint'($signed(ai));
      sbr = longint'($signed(br));
      sbi = longint'($signed(bi));
      nr  = sar * sbr + sai * sbi;
      ni  = sai * sbr - sar * sbi;
      den = sbr * sbr + sbi * sbi;
      e.due = 0;
      if (den == 0) begin
         e.qr = '0;
         e.qi = '0;
         e.ov = 1'b0;
         e.d0 = 1'b1;
      end else begin
         modelComponent(nr, den, e.qr, sr);
         modelComponent(ni, den, e.qi, si);
         e.ov = sr | si;
         e.d0 = 1'b0;
      end
      return e;
   endfunction

   // Hand-computed anchors for the model itself.
   task automatic pinModel();
      exp_t e;
      e = modelDivide(24'h200000, 24'h0, 24'h400000, 24'h0);
      checkOutput("pin_half_qr", 64'(e.qr), 64'(24'h400000));
      checkOutput("pin_half_qi", 64'(e.qi), 64'(24'h0));
      checkOutput("pin_half_ovf", 64'(e.ov), 64'(0));
      e = modelDivide(24'h0, 24'h200000, 24'h0, 24'h400000);
      checkOutput("pin_imag_qr", 64'(e.qr), 64'(24'h400000));
      e = modelDivide(24'h200000, 24'h0, 24'h0, 24'h400000);
      checkOutput("pin_rot_qr", 64'(e.qr), 64'(24'h0));
      checkOutput("pin_rot_qi", 64'(e.qi), 64'(24'hC00000));
      e = modelDivide(24'h400000, 24'h0, 24'h200000, 24'h0);
      checkOutput("pin_satp_qr", 64'(e.qr), 64'(24'h7FFFFF));
      checkOutput("pin_satp_ovf", 64'(e.ov), 64'(1));
      e = modelDivide(24'hC00000, 24'h0, 24'h200000, 24'h0);
      checkOutput("pin_satn_qr", 64'(e.qr), 64'(24'h800000));
      e = modelDivide(24'h123456, 24'h654321, 24'h0, 24'h0);
      checkOutput("pin_div0_flag", 64'(e.d0), 64'(1));
      checkOutput("pin_div0_ovf", 64'(e.ov), 64'(0));
      e = modelDivide(24'h000002, 24'h0, 24'h600000, 24'h0);
`ifdef COMPLEX_DIV_ROUND_EN
      checkOutput("pin_round_qr", 64'(e.qr), 64'(24'h000003));
`else
      checkOutput("pin_trunc_qr", 64'(e.qr), 64'(24'h000002));
`endif
   endtask

   // Waits for an idle cycle (scrambling operands meanwhile), issues start, queues the expectation.
   task automatic applyStimulus(input logic [W-1:0] ar, input logic [W-1:0] ai,
                                input logic [W-1:0] br, input logic [W-1:0] bi,
                                output logic accepted_in_done);
      int   guard;
      exp_t e;
      guard = 0;
      accepted_in_done = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!busy) break;
         a_r = W'($urandom);
         a_i = W'($urandom);
         b_r = W'($urandom);
         b_i = W'($urandom);
         guard++;
         if (guard > 4 * LAT) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_wait: busy still 1 after %0d cycles, required 0", guard);
            return;
         end
      end
      accepted_in_done = done;
      a_r   = ar;
      a_i   = ai;
      b_r   = br;
      b_i   = bi;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e     = modelDivide(ar, ai, br, bi);
      e.due = cyc + LAT;
      pending.push_back(e);
   endtask

   // Cycle-by-cycle compare of every output against the model's view of the operation in flight.
   always @(negedge clk) begin : compare
      logic exp_done, exp_busy;
      exp_done = (pending.size() > 0) && (pending[0].due == cyc);
      exp_busy = (pending.size() > 0) && (cyc < pending[0].due);
      checkOutput("done", 64'(done), 64'(exp_done));
      checkOutput("busy", 64'(busy), 64'(exp_busy));
      if (exp_done) begin
         last_qr = pending[0].qr;
         last_qi = pending[0].qi;
         last_ov = pending[0].ov;
         last_d0 = pending[0].d0;
         void'(pending.pop_front());
      end
      checkOutput("q_r", 64'(q_r), 64'(last_qr));
      checkOutput("q_i", 64'(q_i), 64'(last_qi));
      checkOutput("ovf", 64'(ovf), 64'(last_ov));
      checkOutput("div0", 64'(div0), 64'(last_d0));
   end

   initial begin : watchdog
      #2000000;
      failures++;
      $display("[TB] FAIL watchdog: time limit reached, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : main
      logic         acc_done;
      logic [W-1:0] ar, ai, br, bi;
      int           mode;

      #1 rst_n = 1'b0;
      pinModel();
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] directed vectors");
      applyStimulus(24'h200000, 24'h0, 24'h400000, 24'h0, acc_done);
      applyStimulus(24'h0, 24'h200000, 24'h0, 24'h400000, acc_done);
      applyStimulus(24'h200000, 24'h0, 24'h0, 24'h400000, acc_done);
      applyStimulus(24'h400000, 24'h0, 24'h200000, 24'h0, acc_done);
      applyStimulus(24'hC00000, 24'h0, 24'h200000, 24'h0, acc_done);
      applyStimulus(24'h3ABCDE, 24'hC12345, 24'h0, 24'h0, acc_done);
      applyStimulus(24'h000002, 24'h0, 24'h600000, 24'h0, acc_done);
      applyStimulus(24'hA00000, 24'h0, 24'h600000, 24'h0, acc_done);
      checkOutput("b2b_accept_in_done_cycle", 64'(acc_done), 64'(1));

      $display("[TB] start while busy");
      applyStimulus(24'h123456, 24'hF00000, 24'h5A5A5A, 24'hE12345, acc_done);
      repeat (5) @(negedge clk);
      #1;
      start = 1'b1;
      a_r   = W'($urandom);
      b_r   = 24'h0;
      b_i   = 24'h0;
      @(posedge clk);
      #1;
      start = 1'b0;

      $display("[TB] randomized operations");
      for (int n = 0; n < 60; n++) begin
         ar   = W'($urandom);
         ai   = W'($urandom);
         br   = W'($urandom);
         bi   = W'($urandom);
         mode = int'($urandom_range(0, 4));
         case (mode)
            1: begin
               ar = W'($signed(ar) >>> $urandom_range(1, 8));
               ai = W'($signed(ai) >>> $urandom_range(1, 8));
            end
            2: begin
               br = 24'h0;
               bi = 24'h0;
            end
            3: begin
               ar = -br;
               ai = -bi;
            end
            4: begin
               bi = 24'h0;
               ar = W'($signed(ar) >>> 2);
            end
            default: ;
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
         applyStimulus(ar, ai, br, bi, acc_done);
      end

      $display("[TB] reset during DIV");
      applyStimulus(24'h654321, 24'h111111, 24'h7F0000, 24'h012345, acc_done);
      repeat (12) @(negedge clk);
      #1;
      rst_n = 1'b0;
      pending.delete();
      last_qr = '0;
      last_qi = '0;
      last_ov = 1'b0;
      last_d0 = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'(0));
      checkOutput("abort_q_r", 64'(q_r), 64'(0));
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (LAT + 4) @(negedge clk);

      applyStimulus(24'h200000, 24'h0, 24'h400000, 24'h0, acc_done);
      repeat (LAT + 4) @(negedge clk);
      checkOutput("drain_pending", 64'(pending.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
